load_store_unit: RTL and testbench

Sub-word load/store sequencer between the core's execute stage and the word-wide memory port. It accepts one load or store request at a time and checks alignment and width. It drives one memory transaction with byte-lane data replication and a per-bit write mask, waits for `memory_valid`, then returns the sign- or zero-extended load result, or store completion, as a single-cycle response.

---
 rtl/load_store_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Sub-word load/store sequencer: checks a core request, drives one word-wide memory
// transaction with lane-replicated data and a per-bit mask, and returns a one-cycle response.
`timescale 1ns/1ps

package controller_pkg;
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;
endpackage

module load_store_unit #(
    parameter bit RESP_ON_STORE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    input  logic        memory_ready,
    input  logic        memory_valid,
    input  logic [31:0] read_memory_data,
    output logic [31:0] read_memory_address,
    output logic [31:0] write_memory_address,
    output logic [31:0] write_memory_data,
    output logic [31:0] write_memory_mask,
    output logic        memory_command,
    output logic        memory_enable
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] mem_mask_q, mem_mask_d;
    logic        mem_cmd_q, mem_cmd_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_mis_q, resp_mis_d;
    logic        resp_ill_q, resp_ill_d;
    logic        illegal_s;
    logic        misaligned_s;
    logic        mem_enable_s;

    // BU/HU exist only as loads; every code above W is illegal for stores.
    function automatic logic is_illegal(input logic write, input logic [2:0] f3);
        logic bad;
        case (f3)
            3'b000, 3'b001, 3'b010: bad = 1'b0;
            3'b100, 3'b101:         bad = write;
            default:                bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3)
            3'b001, 3'b101: bad = a[0];
            3'b010:         bad = (a != 2'b00);
            default:        bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] d;
        case (f3)
            3'b000:  d = {4{w[7:0]}};
            3'b001:  d = {2{w[15:0]}};
            3'b010:  d = w;
            default: d = 32'd0;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] m;
        case (f3)
            3'b000: begin
                case (a)
                    2'd0:    m = 32'h0000_00FF;
                    2'd1:    m = 32'h0000_FF00;
                    2'd2:    m = 32'h00FF_0000;
                    default: m = 32'hFF00_0000;
                endcase
            end
            3'b001:  m = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            3'b010:  m = 32'hFFFF_FFFF;
            default: m = 32'd0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Next-state, request capture and response formation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        write_d      = write_q;
        mem_wdata_d  = mem_wdata_q;
        mem_mask_d   = mem_mask_q;
        mem_cmd_d    = mem_cmd_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_mis_d   = resp_mis_q;
        resp_ill_d   = resp_ill_q;
        mem_enable_s = 1'b0;
        illegal_s    = is_illegal(req_write, req_funct3);
        misaligned_s = !illegal_s && is_misaligned(req_funct3, req_address[1:0]);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d       = req_address;
                    funct3_d     = req_funct3;
                    write_d      = req_write;
                    mem_cmd_d    = req_write ? controller_pkg::WRITE : controller_pkg::READ;
                    mem_wdata_d  = req_write ? store_data(req_funct3, req_wdata) : 32'd0;
                    mem_mask_d   = req_write ? store_mask(req_funct3, req_address[1:0]) : 32'd0;
                    resp_rdata_d = 32'd0;
                    resp_ill_d   = illegal_s;
                    resp_mis_d   = misaligned_s;
                    if (illegal_s || misaligned_s) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (memory_ready) begin
                    mem_enable_s = 1'b1;
                    // Posted stores complete without waiting for memory_valid.
                    if (write_q && !RESP_ON_STORE) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                if (memory_valid) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = write_q ? 32'd0 : load_extract(funct3_q, addr_q[1:0], read_memory_data);
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d      = IDLE;
                resp_rdata_d = 32'd0;
                resp_mis_d   = 1'b0;
                resp_ill_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            funct3_q     <= 3'd0;
            write_q      <= 1'b0;
            mem_wdata_q  <= 32'd0;
            mem_mask_q   <= 32'd0;
            mem_cmd_q    <= controller_pkg::READ;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_mis_q   <= 1'b0;
            resp_ill_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            write_q      <= write_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_mask_q   <= mem_mask_d;
            mem_cmd_q    <= mem_cmd_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
            resp_ill_q   <= resp_ill_d;
        end
    end

    assign req_ready            = (state_q == IDLE);
    assign memory_enable        = mem_enable_s;
    assign resp_valid           = resp_valid_q;
    assign resp_rdata           = resp_rdata_q;
    assign resp_misaligned      = resp_mis_q;
    assign resp_illegal         = resp_ill_q;
    assign read_memory_address  = addr_q;
    assign write_memory_address = addr_q;
    assign write_memory_data    = mem_wdata_q;
    assign write_memory_mask    = mem_mask_q;
    assign memory_command       = mem_cmd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a cycle-stepped memory responder plus
// per-scenario tasks comparing latency, extracted data, lanes, masks and error flags.
`timescale 1ns/1ps

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address, req_wdata;
    logic        resp_valid, resp_misaligned, resp_illegal;
    logic [31:0] resp_rdata;
    logic        memory_ready, memory_valid;
    logic [31:0] read_memory_data;
    logic [31:0] read_memory_address, write_memory_address, write_memory_data, write_memory_mask;
    logic        memory_command, memory_enable;

    load_store_unit #(.RESP_ON_STORE(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
        .memory_ready(memory_ready), .memory_valid(memory_valid),
        .read_memory_data(read_memory_data),
        .read_memory_address(read_memory_address), .write_memory_address(write_memory_address),
        .write_memory_data(write_memory_data), .write_memory_mask(write_memory_mask),
        .memory_command(memory_command), .memory_enable(memory_enable)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] WORD = 32'h80FF_1234;
    localparam logic [165:0] RESET_VIEW = {1'b1, 5'b00000, 160'd0};

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    int          obs_lat, obs_en_cyc;
    logic        obs_ready, obs_mis, obs_ill, obs_cmd, obs_addr_moved;
    logic [31:0] obs_rdata, obs_wdata, obs_mask;

    // Drives one request from a falling edge and plays memory until the response or a timeout.
    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word, input int stall);
        int cyc;
        bit pend;
        memory_ready = 1'b1;
        memory_valid = 1'b0;
        req_valid   = 1'b1;
        req_write   = w;
        req_funct3  = f3;
        req_address = addr;
        req_wdata   = wdata;
        #1 obs_ready = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        obs_lat = -1; obs_en_cyc = -1; obs_addr_moved = 1'b0; pend = 1'b0; cyc = 1;
        obs_rdata = 32'hX; obs_mis = 1'bx; obs_ill = 1'bx;
        obs_wdata = 32'hX; obs_mask = 32'hX; obs_cmd = 1'bx;
        while (cyc < 40 && obs_lat < 0) begin
            memory_ready     = (cyc > stall);
            memory_valid     = pend;
            read_memory_data = pend ? word : 32'hDEAD_BEEF;
            pend = 1'b0;
            #1;
            if (resp_valid) begin
                obs_lat = cyc; obs_rdata = resp_rdata; obs_mis = resp_misaligned; obs_ill = resp_illegal;
            end else begin
                if (read_memory_address !== addr || write_memory_address !== addr) obs_addr_moved = 1'b1;
                if (memory_enable === 1'b1 && obs_en_cyc < 0) begin
                    obs_en_cyc = cyc; obs_wdata = write_memory_data;
                    obs_mask = write_memory_mask; obs_cmd = memory_command; pend = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        memory_valid = 1'b0;
        memory_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_address = 32'd0; req_wdata = 32'd0;
        memory_ready = 1'b1; memory_valid = 1'b0; read_memory_data = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_misaligned, resp_illegal, memory_enable, memory_command,
             resp_rdata, read_memory_address, write_memory_address, write_memory_data,
             write_memory_mask} !== RESET_VIEW) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b en=%b cmd=%b rd=%h addr=%h wd=%h mask=%h, expected rdy=1 others 0",
                     req_ready, resp_valid, memory_enable, memory_command, resp_rdata,
                     read_memory_address, write_memory_data, write_memory_mask);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got ready=%b resp_valid=%b, expected 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3;
        logic [31:0] addr, exp_data;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       begin f3 = 3'b000; addr = 32'h8000_0003; exp_data = 32'hFFFF_FF80; end
                1:       begin f3 = 3'b100; addr = 32'h8000_0003; exp_data = 32'h0000_0080; end
                2:       begin f3 = 3'b000; addr = 32'h8000_0001; exp_data = 32'h0000_0012; end
                3:       begin f3 = 3'b001; addr = 32'h8000_0002; exp_data = 32'hFFFF_80FF; end
                4:       begin f3 = 3'b101; addr = 32'h8000_0002; exp_data = 32'h0000_80FF; end
                5:       begin f3 = 3'b001; addr = 32'h8000_0000; exp_data = 32'h0000_1234; end
                default: begin f3 = 3'b010; addr = 32'h8000_0004; exp_data = 32'h80FF_1234; end
            endcase
            sb_q.push_back('{rdata: exp_data, mis: 1'b0, ill: 1'b0, lat: 3});
            run_txn(1'b0, f3, addr, 32'hFFFF_FFFF, WORD, 0);
            e = sb_q.pop_front();
            checks++;
            if (obs_lat !== e.lat || obs_en_cyc !== 1) begin
                failures++;
                $display("FAIL load_timing[%0d]: got resp T+%0d enable T+%0d, expected T+%0d / T+1", i, obs_lat, obs_en_cyc, e.lat);
            end
            checks++;
            if (obs_rdata !== e.rdata || obs_mis !== e.mis || obs_ill !== e.ill || obs_cmd !== controller_pkg::READ) begin
                failures++;
                $display("FAIL load_data[%0d]: got %h mis=%b ill=%b cmd=%b, expected %h 0 0 READ", i, obs_rdata, obs_mis, obs_ill, obs_cmd, e.rdata);
            end
            checks++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0 || obs_addr_moved !== 1'b0) begin
                failures++;
                $display("FAIL load_after[%0d]: got ready=%b resp_valid=%b addr_moved=%b, expected 1 0 0", i, req_ready, resp_valid, obs_addr_moved);
            end
        end
    endtask

    task automatic test_stores();
        logic [2:0]  f3;
        logic [31:0] addr, wdata, exp_wd, exp_mask;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       begin f3 = 3'b001; addr = 32'h8000_0002; wdata = 32'h0000_BEEF; exp_wd = 32'hBEEF_BEEF; exp_mask = 32'hFFFF_0000; end
                1:       begin f3 = 3'b000; addr = 32'h8000_0001; wdata = 32'h1234_56A5; exp_wd = 32'hA5A5_A5A5; exp_mask = 32'h0000_FF00; end
                2:       begin f3 = 3'b010; addr = 32'h8000_0004; wdata = 32'hCAFE_F00D; exp_wd = 32'hCAFE_F00D; exp_mask = 32'hFFFF_FFFF; end
                default: begin f3 = 3'b000; addr = 32'h8000_0003; wdata = 32'h0000_005A; exp_wd = 32'h5A5A_5A5A; exp_mask = 32'hFF00_0000; end
            endcase
            sb_q.push_back('{rdata: 32'd0, mis: 1'b0, ill: 1'b0, lat: 3});
            run_txn(1'b1, f3, addr, wdata, WORD, 0);
            e = sb_q.pop_front();
            checks++;
            if (obs_wdata !== exp_wd || obs_mask !== exp_mask || obs_cmd !== controller_pkg::WRITE) begin
                failures++;
                $display("FAIL store_lanes[%0d]: got data=%h mask=%h cmd=%b, expected %h %h WRITE", i, obs_wdata, obs_mask, obs_cmd, exp_wd, exp_mask);
            end
            checks++;
            if (obs_lat !== e.lat || obs_en_cyc !== 1 || obs_rdata !== e.rdata || obs_mis !== 1'b0 || obs_ill !== 1'b0) begin
                failures++;
                $display("FAIL store_resp[%0d]: got resp T+%0d en T+%0d rdata=%h, expected T+%0d T+1 %h", i, obs_lat, obs_en_cyc, obs_rdata, e.lat, e.rdata);
            end
        end
    endtask

    task automatic test_errors();
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        mis, ill;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       begin w = 1'b0; f3 = 3'b010; addr = 32'h8000_0006; mis = 1'b1; ill = 1'b0; end
                1:       begin w = 1'b0; f3 = 3'b011; addr = 32'h8000_0000; mis = 1'b0; ill = 1'b1; end
                2:       begin w = 1'b0; f3 = 3'b101; addr = 32'h8000_0001; mis = 1'b1; ill = 1'b0; end
                3:       begin w = 1'b1; f3 = 3'b100; addr = 32'h8000_0000; mis = 1'b0; ill = 1'b1; end
                4:       begin w = 1'b1; f3 = 3'b011; addr = 32'h8000_0000; mis = 1'b0; ill = 1'b1; end
                5:       begin w = 1'b1; f3 = 3'b001; addr = 32'h8000_0003; mis = 1'b1; ill = 1'b0; end
                default: begin w = 1'b0; f3 = 3'b111; addr = 32'h8000_0000; mis = 1'b0; ill = 1'b1; end
            endcase
            sb_q.push_back('{rdata: 32'd0, mis: mis, ill: ill, lat: 1});
            run_txn(w, f3, addr, 32'h1234_5678, WORD, 0);
            e = sb_q.pop_front();
            checks++;
            if (obs_lat !== e.lat || obs_mis !== e.mis || obs_ill !== e.ill || obs_rdata !== e.rdata) begin
                failures++;
                $display("FAIL error_resp[%0d]: got T+%0d mis=%b ill=%b rdata=%h, expected T+%0d %b %b %h",
                         i, obs_lat, obs_mis, obs_ill, obs_rdata, e.lat, e.mis, e.ill, e.rdata);
            end
            checks++;
            if (obs_en_cyc !== -1 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL error_nomem[%0d]: got enable T+%0d ready=%b, expected none and 1", i, obs_en_cyc, req_ready);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        sb_q.push_back('{rdata: 32'h0000_1234, mis: 1'b0, ill: 1'b0, lat: 7});
        run_txn(1'b0, 3'b101, 32'h8000_0000, 32'd0, WORD, 4);
        e = sb_q.pop_front();
        checks++;
        if (obs_lat !== e.lat || obs_en_cyc !== 5 || obs_rdata !== e.rdata) begin
            failures++;
            $display("FAIL stall_resp: got T+%0d en T+%0d rdata=%h, expected T+%0d T+5 %h", obs_lat, obs_en_cyc, obs_rdata, e.lat, e.rdata);
        end
        checks++;
        if (obs_addr_moved !== 1'b0 || obs_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_addr: got addr_moved=%b ready_at_req=%b, expected 0 1", obs_addr_moved, obs_ready);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb_q.push_back('{rdata: 32'd0, mis: 1'b1, ill: 1'b0, lat: 1});
        sb_q.push_back('{rdata: 32'd0, mis: 1'b0, ill: 1'b1, lat: 3});
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h8000_0006;
        @(negedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (resp_valid !== 1'b1 || resp_misaligned !== e.mis || resp_illegal !== e.ill || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: got rv=%b mis=%b ill=%b ready=%b, expected 1 %b %b 0", resp_valid, resp_misaligned, resp_illegal, req_ready, e.mis, e.ill);
        end
        req_funct3 = 3'b011; req_address = 32'h8000_0000;
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap: got rv=%b ready=%b, expected 0 1", resp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        e = sb_q.pop_front();
        checks++;
        if (resp_valid !== 1'b1 || resp_misaligned !== e.mis || resp_illegal !== e.ill || resp_rdata !== e.rdata) begin
            failures++;
            $display("FAIL b2b_second: got rv=%b mis=%b ill=%b rdata=%h, expected 1 %b %b %h", resp_valid, resp_misaligned, resp_illegal, resp_rdata, e.mis, e.ill, e.rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int stray;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h8000_0000;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (memory_enable !== 1'b1) begin
            failures++;
            $display("FAIL abort_issue: got memory_enable=%b, expected 1", memory_enable);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || memory_enable !== 1'b0 || read_memory_address !== 32'd0) begin
            failures++;
            $display("FAIL abort_async: got ready=%b en=%b addr=%h, expected 1 0 0", req_ready, memory_enable, read_memory_address);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        memory_valid = 1'b1; read_memory_data = WORD;
        @(negedge clk);
        memory_valid = 1'b0;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (resp_valid !== 1'b0) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL abort_no_resp: got %0d resp_valid cycles, expected 0", stray);
        end
        checks++;
        if ({req_ready, resp_valid, resp_misaligned, resp_illegal, memory_enable, memory_command,
             resp_rdata, read_memory_address, write_memory_address, write_memory_data,
             write_memory_mask} !== RESET_VIEW) begin
            failures++;
            $display("FAIL abort_outputs: got rdy=%b rv=%b en=%b cmd=%b rd=%h addr=%h wd=%h mask=%h, expected rdy=1 others 0",
                     req_ready, resp_valid, memory_enable, memory_command, resp_rdata,
                     read_memory_address, write_memory_data, write_memory_mask);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
